// File: rtl/tohost_monitor.sv
// Snoops a valid/ready write channel for stores to the tohost word and turns exit codes into
// sticky io_success / io_failure verdicts. Optional idle watchdog under `TOHOST_WATCHDOG_EN.
module tohost_monitor #(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR     = ADDR_W'(32'h8000_1000),
    parameter int                DRAIN_CYCLES    = 16,
    parameter logic [31:0]       WATCHDOG_CYCLES = 32'd1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              io_success,
    output logic              io_failure,
    output logic [DATA_W-2:0] fail_code,
    output logic [15:0]       host_req_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        PASS,
        FAIL
    } state_e;

    state_e             state;
    logic [DRAIN_W-1:0] drain_cnt;

    logic hit;
    logic hit_exit;
    logic hit_host;

    assign hit      = req_valid && req_ready && (req_addr == TOHOST_ADDR);
    assign hit_exit = hit && req_data[0];
    assign hit_host = hit && !req_data[0] && (req_data != '0);

`ifdef TOHOST_WATCHDOG_EN
    logic [31:0] idle_cnt;
    logic        wd_expired;

    // A matched write on the expiry edge keeps the test alive; an exit write on it drains normally.
    assign wd_expired = (idle_cnt == WATCHDOG_CYCLES) && !hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (state != IDLE || hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic wd_expired;
    assign wd_expired = 1'b0;
`endif

    // NOTE: every register here is updated with <= so all next-state terms read pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            req_ready      <= 1'b0;
            drain_cnt      <= '0;
            io_success     <= 1'b0;
            io_failure     <= 1'b0;
            fail_code      <= '0;
            host_req_count <= '0;
        end else begin
            req_ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (hit_exit) begin
                        fail_code <= req_data[DATA_W-1:1];
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
                        state     <= DRAIN;
                    end else if (hit_host) begin
                        if (host_req_count != 16'hFFFF) begin
                            host_req_count <= host_req_count + 16'd1;
                        end
                    end else if (wd_expired) begin
                        fail_code  <= '1;
                        io_failure <= 1'b1;
                        state      <= FAIL;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (fail_code == '0) begin
                            io_success <= 1'b1;
                            state      <= PASS;
                        end else begin
                            io_failure <= 1'b1;
                            state      <= FAIL;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                PASS, FAIL: begin
                    state <= state;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Test-harness monitor that snoops a valid/ready write channel for stores to the `tohost` word and converts them into the `io_success` / `io_failure` pulses consumed by the top-level test driver. It is the stage directly upstream of the simulation driver: the driver only watches `io_success` and enforces the global cycle timeout. This block decodes the exit code, counts host-request writes, and optionally provides a per-test watchdog. It holds its verdict after a drain window, so in-flight traffic settles before the driver ends simulation.

## Interface
- `ADDR_W`, 32, request address width
- `DATA_W`, 64, request data width (≥2)
- `TOHOST_ADDR`, 32'h8000_1000, byte address of the `tohost` word
- `DRAIN_CYCLES`, 16, cycles between the accepted exit write and the verdict (0 allowed)
- `WATCHDOG_CYCLES`, 32'd1_000_000, idle-cycle limit; used only with the watchdog macro
- `clk`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately
- `req_valid`  in  1  write request valid
- `req_ready`  out  1  write request accepted when high with `req_valid`
- `req_addr`  in  ADDR_W  write byte address
- `req_data`  in  DATA_W  write data
- `io_success`  out  1  test passed; sticky until reset
- `io_failure`  out  1  test failed; sticky until reset
- `fail_code`  out  DATA_W-1  latched exit code (`req_data >> 1`)
- `host_req_count`  out  16  number of non-exit, nonzero `tohost` writes (saturating)

## Operation
- States: IDLE, DRAIN, PASS, FAIL.
- Registered outputs. All outputs and counters reset to 0. State resets to IDLE.
- `req_ready` is a register. It is 0 during reset and 1 from the first rising edge after `reset` goes high, then stays 1. The sink never stalls.
- An accept is `req_valid && req_ready` at a rising edge. It is a match when `req_addr == TOHOST_ADDR`. Non-matching accepts have no effect.
- IDLE, matched accept:
  - `req_data == 0`: ignored.
  - `req_data[0] == 1` (exit): latch `fail_code = req_data[DATA_W-1:1]`, load `drain_cnt = DRAIN_CYCLES`, and go to DRAIN.
  - Otherwise (host request): `host_req_count` increments and saturates at 16'hFFFF.
- DRAIN:
  - `drain_cnt == 0`: next state is PASS if `fail_code == 0`, else FAIL.
  - Otherwise: `drain_cnt` decrements.
  - Matched writes in DRAIN are accepted and ignored. The first exit wins.
- PASS: `io_success = 1`. FAIL: `io_failure = 1`. Both states are terminal until reset. All accepts are ignored, and `host_req_count` and `fail_code` are frozen.
- `io_success` and `io_failure` are never high together.
- Reset asserted mid-DRAIN or in a terminal state returns asynchronously to IDLE. All outputs go to 0 and the latched code is lost.

## Timing
- Exit accepted at edge N: DRAIN is entered at edge N. The verdict flag rises after edge N+DRAIN_CYCLES+1 and is stable from then on.
- With `DRAIN_CYCLES = 0`, the flag rises after edge N+1.
- `host_req_count` updates at the accepting edge and is visible the next cycle.
- Drain counter width is `$clog2(DRAIN_CYCLES+1)`, minimum 1 bit.

## Configuration
- `TOHOST_WATCHDOG_EN` defined:
  - A 32-bit idle counter runs in IDLE only. It clears on reset and on every matched accept (any data).
  - When the counter reaches `WATCHDOG_CYCLES`, the block sets `fail_code` to all ones and goes straight to FAIL, with no drain. `io_failure` rises after the next edge.
  - If an exit write is accepted on the same edge the counter expires, the exit write wins and follows normal DRAIN handling.
- `TOHOST_WATCHDOG_EN` undefined:
  - No counter is built and `WATCHDOG_CYCLES` is ignored.
  - FAIL is reachable only via a nonzero exit code.

## Test plan
- Pass, default parameters: write 64'h1 to 32'h8000_1000 at edge N. Expect `io_success = 1` after edge N+17, `io_failure = 0`, `fail_code = 0`.
- Fail code: write 64'h7 (code 3). Expect `io_failure = 1` after the drain and `fail_code = 3`. Then write 64'h1 and expect no change.
- Host requests and filtering:
  - Write 64'h10 three times to `TOHOST_ADDR`: expect `host_req_count = 3`.
  - Write 64'h1 to 32'h8000_1008 and write 64'h0 to `TOHOST_ADDR`: expect no state change.
  - Preload the count at 16'hFFFF: expect it to saturate.
- Reset mid-drain: after an exit write, drive `reset = 0` four cycles into DRAIN. Expect all outputs 0 immediately and no verdict afterwards. Then a new exit write of 64'h1 yields `io_success = 1`.
- `DRAIN_CYCLES = 0`: exit write 64'h1 at edge N. Expect `io_success = 1` after edge N+1.
- Watchdog, with `TOHOST_WATCHDOG_EN` and `WATCHDOG_CYCLES = 100`:
  - No matched writes: expect `io_failure = 1` and `fail_code` all ones around cycle 101.
  - Exit write on the expiry edge: expect normal drain and pass.
